// File: rtl/fu_issue_ctrl.sv
// Issue controller for a combinational function unit: accepts one request,
// iterates it i_req_rep extra times by feeding the result back into operand b,
// then holds the final result until the consumer takes it.
module fu_issue_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [4:0]       i_req_fs,
  input  logic [3:0]       i_req_sel_a,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic [3:0]       i_req_rep,
  output logic [WIDTH-1:0] o_fu_opr_a,
  output logic [WIDTH-1:0] o_fu_opr_b,
  output logic [3:0]       o_fu_sel_a,
  output logic [4:0]       o_fu_fs,
  input  logic [WIDTH-1:0] i_fu_func,
  input  logic             i_fu_n,
  input  logic             i_fu_z,
  input  logic             i_fu_v,
  input  logic             i_fu_c,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic [3:0]       o_status,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] opr_a_q;
  logic [WIDTH-1:0] opr_b_q;
  logic [4:0]       fs_q;
  logic [3:0]       sel_a_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [3:0]       status_q;

  // Controller FSM with operand, counter, result and status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      opr_a_q    <= '0;
      opr_b_q    <= '0;
      fs_q       <= 5'd0;
      sel_a_q    <= 4'd0;
      rsp_data_q <= '0;
      status_q   <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req_valid) begin
            opr_a_q <= i_req_a;
            opr_b_q <= i_req_b;
            fs_q    <= i_req_fs;
            sel_a_q <= i_req_sel_a;
            cnt_q   <= i_req_rep;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != 4'd0) begin
            // Feed the result back as the next operand b.
            opr_b_q <= i_fu_func;
            cnt_q   <= cnt_q - 4'd1;
          end else begin
            rsp_data_q <= i_fu_func;
            // fs[4] selects operations whose flags must not disturb status.
            if (!fs_q[4]) begin
              status_q <= {i_fu_n, i_fu_z, i_fu_v, i_fu_c};
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state; ready is also masked by reset.
  always_comb begin
    o_req_ready = (state_q == StIdle) && !i_rst;
    o_rsp_valid = (state_q == StResp);
    o_busy      = (state_q != StIdle);
    o_fu_opr_a  = opr_a_q;
    o_fu_opr_b  = opr_b_q;
    o_fu_sel_a  = sel_a_q;
    o_fu_fs     = fs_q;
    o_rsp_data  = rsp_data_q;
    o_status    = status_q;
  end

endmodule

// File: doc/fu_issue_ctrl.md
FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath operand/result width.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_req_valid  input  1  operation request valid.
REQ-005 SHALL have port o_req_ready  output  1  controller can accept a request.
REQ-006 SHALL have ports i_req_fs  input  5, i_req_sel_a  input  4, i_req_a  input  WIDTH, i_req_b  input  WIDTH  request function select, shift-amount select and operands.
REQ-007 SHALL have port i_req_rep  input  4  extra iteration count (0 = single execution).
REQ-008 SHALL have ports o_fu_opr_a, o_fu_opr_b  output  WIDTH, o_fu_sel_a  output  4, o_fu_fs  output  5  drive to function unit.
REQ-009 SHALL have ports i_fu_func  input  WIDTH, i_fu_n, i_fu_z, i_fu_v, i_fu_c  input  1 each  combinational function unit result and flags.
REQ-010 SHALL have port o_rsp_valid  output  1  result available.
REQ-011 SHALL have port i_rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports o_rsp_data  output  WIDTH  result, o_status  output  4  registered flags {N,Z,V,C}, o_busy  output  1  state != IDLE.

Function
REQ-013 SHALL implement states IDLE, EXEC, RESP.
REQ-014 SHALL assert o_req_ready only in IDLE and not while i_rst is high; request accepted on edge where i_req_valid & o_req_ready.
REQ-015 On acceptance SHALL latch a, b, fs, sel_a into operand registers, load iteration counter with i_req_rep, and enter EXEC.
REQ-016 SHALL drive o_fu_* directly from the operand registers in all states; values held after completion until next acceptance.
REQ-017 In EXEC with counter != 0 SHALL, each edge, load operand-b register with i_fu_func, decrement counter, remain in EXEC; operand a, fs, sel_a unchanged.
REQ-018 In EXEC with counter == 0 SHALL capture i_fu_func into o_rsp_data and enter RESP.
REQ-019 SHALL update o_status from i_fu_{n,z,v,c} on the final EXEC edge only when latched fs[4] == 0; when fs[4] == 1 o_status SHALL hold its prior value.
REQ-020 Latency: o_rsp_valid SHALL rise exactly i_req_rep+1 edges after the acceptance edge (rep=15 gives 16 executions, no counter wrap).
REQ-021 In RESP SHALL hold o_rsp_valid high and o_rsp_data stable until i_rsp_ready is high, then return to IDLE on that edge.
REQ-022 i_rsp_ready high in the first RESP cycle SHALL complete the handshake that cycle; no request accepted in the same cycle (no bypass), earliest acceptance next cycle.
REQ-023 i_req_valid while not IDLE SHALL be ignored with no latching of request inputs.
REQ-024 o_rsp_valid SHALL be low in IDLE and EXEC; i_rsp_ready outside RESP SHALL have no effect.

Reset
REQ-025 i_rst high SHALL immediately force state IDLE, counter 0, operand registers 0, o_rsp_data 0, o_status 4'b0000, o_rsp_valid 0, o_busy 0, o_req_ready 0.
REQ-026 Reset during EXEC or RESP SHALL abort the operation with no response produced; first acceptance possible in the first cycle after i_rst deasserts.

Verification (bench FU model: fs[4]=0 -> func=a+b with standard NZVC; fs[4]=1 -> func=b<<1, flags 0)
REQ-027 Assert i_rst -> all outputs zero, o_req_ready 0; release -> o_req_ready 1 next cycle, o_busy 0.
REQ-028 fs=5'b00000, a=3, b=4, rep=0 -> o_rsp_valid 1 edge after acceptance, o_rsp_data=16'h0007, o_status=4'b0000.
REQ-029 fs=5'b00000, a=16'h7FFF, b=16'h0001, rep=0 -> o_rsp_data=16'h8000, o_status=4'b1010.
REQ-030 After REQ-029, fs=5'b10000, b=16'h0001, rep=3 -> o_rsp_valid 4 edges after acceptance, o_rsp_data=16'h0010, o_status stays 4'b1010.
REQ-031 Hold i_rsp_ready low 5 cycles in RESP while pulsing i_req_valid -> o_rsp_data stable, o_req_ready 0, no new request latched; raise i_rsp_ready -> IDLE next edge.
REQ-032 rep=10, assert i_rst 3 cycles after acceptance -> o_rsp_valid never rises, state IDLE, o_status 4'b0000.
